record_replay_ctrl: RTL and testbench

//  Multi-channel record/replay controller. Registers W-bit samples, streams a run-time

---
 rtl/record_replay_pkg.sv | 19 +
 rtl/rr_combine.sv | 27 ++
 rtl/record_replay_ctrl.sv | 161 ++++++++++++++++
 tb/tb_record_replay_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/record_replay_pkg.sv
// Shared encodings for the record/replay controller: FSM states and the
// live-vs-replay combine modes.
package record_replay_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RECORD = 3'd2,
    S_WAIT   = 3'd3,
    S_REPLAY = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

endpackage

// File: rtl/rr_combine.sv
// Combines the live sample with the replayed sample according to mode.
// The output is forced to zero whenever no replayed sample is present.
module rr_combine
  import record_replay_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] live,
  input  logic [W-1:0] replay,
  input  logic         valid,
  output logic [W-1:0] comb
);

  always_comb begin
    comb = '0;
    if (valid) begin
      case (mode)
        MODE_AND: comb = live & replay;
        MODE_OR:  comb = live | replay;
        MODE_XOR: comb = live ^ replay;
        default:  comb = replay;
      endcase
    end
  end

endmodule

// File: rtl/record_replay_ctrl.sv
// Record/replay controller: streams L registered samples into an external FIFO,
// waits for a second start, reads L samples back and combines them with live data.
module record_replay_ctrl
  import record_replay_pkg::*;
#(
  parameter int W     = 1,
  parameter int M_MAX = 28000,
  parameter int N     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] rec_len,
  input  logic [1:0]   mode,
  input  logic [W-1:0] din,
  input  logic [W-1:0] from_fifo,
  input  logic         fifo_full,
  input  logic         fifo_empty,
  output logic [W-1:0] dout,
  output logic [W-1:0] to_fifo,
  output logic         wr_en,
  output logic         rd_en,
  output logic [W-1:0] shifted_dout,
  output logic         rep_valid,
  output logic [W-1:0] dout_comb,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err,
  output logic [2:0]   dbg_state
);

  localparam logic [N-1:0] L_MAX = N'(M_MAX);
  localparam logic [N-1:0] ONE   = N'(1);

  // FIFO handshake: a write is accepted on a clock edge where wr_en=1 and
  // fifo_full=0; a read is accepted where rd_en=1 and fifo_empty=0, and its data
  // appears on from_fifo one cycle later. wr_en/rd_en high against full/empty
  // is an overflow/underflow and terminates the run.
  state_t       state, state_d;
  logic [N-1:0] cnt, cnt_d;
  logic [N-1:0] len, len_d;
  logic         wr_en_d, rd_en_d, done_d;
  logic [1:0]   err_d;
  logic         start_q, rd_q;
  logic         start_edge;

  assign start_edge = start & ~start_q;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    len_d   = len;
    wr_en_d = wr_en;
    rd_en_d = rd_en;
    err_d   = err;
    done_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_edge && !abort && (rec_len != '0)) begin
          len_d   = (rec_len > L_MAX) ? L_MAX : rec_len;
          err_d   = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        cnt_d   = '0;
        wr_en_d = 1'b1;
        state_d = S_RECORD;
      end
      S_RECORD: begin
        if (fifo_full && wr_en) begin
          err_d[0] = 1'b1;
          wr_en_d  = 1'b0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else if (cnt == len - ONE) begin
          wr_en_d = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      S_WAIT: begin
        if (start_edge) begin
          rd_en_d = 1'b1;
          state_d = S_REPLAY;
        end
      end
      S_REPLAY: begin
        if (fifo_empty && rd_en) begin
          err_d[1] = 1'b1;
          rd_en_d  = 1'b0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else if (cnt == len - ONE) begin
          rd_en_d = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // DONE already leads straight back to IDLE, so abort only matters before it.
    if (abort && (state != S_IDLE) && (state != S_DONE)) begin
      state_d = S_DONE;
      wr_en_d = 1'b0;
      rd_en_d = 1'b0;
      cnt_d   = '0;
    end
    if ((state_d == S_DONE) && (state != S_DONE)) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      len          <= '0;
      wr_en        <= 1'b0;
      rd_en        <= 1'b0;
      err          <= '0;
      done         <= 1'b0;
      start_q      <= 1'b0;
      rd_q         <= 1'b0;
      rep_valid    <= 1'b0;
      dout         <= '0;
      to_fifo      <= '0;
      shifted_dout <= '0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      len          <= len_d;
      wr_en        <= wr_en_d;
      rd_en        <= rd_en_d;
      err          <= err_d;
      done         <= done_d;
      start_q      <= start;
      // Only accepted reads produce data, so the valid pipeline drains naturally.
      rd_q         <= rd_en & ~fifo_empty;
      rep_valid    <= rd_q;
      dout         <= din;
      to_fifo      <= din;
      shifted_dout <= from_fifo;
    end
  end

  rr_combine #(.W(W)) u_combine (
    .mode   (mode),
    .live   (dout),
    .replay (shifted_dout),
    .valid  (rep_valid),
    .comb   (dout_comb)
  );

endmodule

// File: tb/tb_record_replay_ctrl.sv
// Directed bench for record_replay_ctrl with a behavioural FIFO and an
// expected-sample queue for replayed data.
module tb_record_replay_ctrl;
  import record_replay_pkg::*;

  localparam int W     = 4;
  localparam int N     = 16;
  localparam int M_MAX = 28000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] rec_len = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] din = '0;
  logic [W-1:0] from_fifo = '0;
  logic         fifo_full, fifo_empty;
  logic [W-1:0] dout, to_fifo, shifted_dout, dout_comb;
  logic         wr_en, rd_en, rep_valid, busy, done;
  logic [1:0]   err;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] comb_seen[0:15];
  int           n_seen;

  // Clock and reset
  always #5 clk = ~clk;

  record_replay_ctrl #(.W(W), .M_MAX(M_MAX), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .rec_len      (rec_len),
    .mode         (mode),
    .din          (din),
    .from_fifo    (from_fifo),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .dout         (dout),
    .to_fifo      (to_fifo),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .shifted_dout (shifted_dout),
    .rep_valid    (rep_valid),
    .dout_comb    (dout_comb),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // Behavioural FIFO, one-cycle read latency
  logic [W-1:0] fifo_q[$];
  int           fifo_n = 0;
  logic         force_full = 1'b0;
  logic         force_empty = 1'b0;
  logic         flush = 1'b0;

  assign fifo_full  = force_full || (fifo_n >= 32768);
  assign fifo_empty = force_empty || (fifo_n == 0);

  always @(posedge clk) begin
    if (flush) begin
      fifo_q.delete();
    end else begin
      if (wr_en && !fifo_full) fifo_q.push_back(to_fifo);
      if (rd_en && !fifo_empty) from_fifo <= fifo_q.pop_front();
    end
    fifo_n <= fifo_q.size();
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic record_seq(input int len, input logic [W-1:0] first);
    rec_len = N'(len);
    din     = first;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rec_arm_state", dbg_state, S_ARM);
    check_eq("rec_arm_wr", wr_en, 0);
    for (int k = 0; k < len; k++) begin
      tick();
      check_eq("rec_wr_en", wr_en, 1);
      check_eq("rec_to_fifo", to_fifo, first + W'(k));
      exp_q.push_back(first + W'(k));
      din = first + W'(k + 1);
    end
    tick();
    check_eq("rec_wr_end", wr_en, 0);
    check_eq("rec_wait_state", dbg_state, S_WAIT);
  endtask

  task automatic replay_seq(input int len);
    logic [W-1:0] exp_v;
    n_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < len + 4; i++) begin
      check_eq("rep_rd_en", rd_en, (i < len) ? 1 : 0);
      check_eq("rep_done", done, (i == len) ? 1 : 0);
      check_eq("rep_valid", rep_valid, (i >= 2 && i < len + 2) ? 1 : 0);
      if (rep_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rep_extra_sample", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check_eq("rep_shifted", shifted_dout, exp_v);
        end
        comb_seen[n_seen] = dout_comb;
        n_seen++;
      end else begin
        check_eq("rep_comb_idle", dout_comb, 0);
      end
      tick();
    end
    check_eq("rep_end_state", dbg_state, S_IDLE);
  endtask

  logic [W-1:0] xor_exp[0:4];
  logic [W-1:0] pass_exp[0:2];
  int           wr_count;

  initial begin
    xor_exp  = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hA};
    pass_exp = '{4'h7, 4'h8, 4'h9};

    // Reset state
    @(negedge clk);
    tick();
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_rd_en", rd_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_comb", dout_comb, 0);
    rst = 1'b1;
    tick();

    // Record 1..5, replay under XOR with live data held at F
    mode = MODE_XOR;
    record_seq(5, 4'h1);
    din = 4'hF;
    tick();
    check_eq("wait_hold_wr", wr_en, 0);
    check_eq("wait_hold_rd", rd_en, 0);
    replay_seq(5);
    check_eq("t1_seen", n_seen, 5);
    for (int i = 0; i < 5; i++) check_eq("t2_xor_comb", comb_seen[i], xor_exp[i]);
    check_eq("t1_err", err, 0);

    // Overflow on the third write
    flush_fifo();
    rec_len = 16'd5;
    din     = 4'h2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("ovf_wr_en", wr_en, 1);
    end
    force_full = 1'b1;
    tick();
    force_full = 1'b0;
    check_eq("ovf_wr_low", wr_en, 0);
    check_eq("ovf_err", err, 2'b01);
    check_eq("ovf_done", done, 1);
    check_eq("ovf_state", dbg_state, S_DONE);
    tick();
    check_eq("ovf_idle", dbg_state, S_IDLE);
    check_eq("ovf_err_sticky", err, 2'b01);

    // Abort beats a start edge in WAIT; err cleared by the accepted start
    flush_fifo();
    exp_q.delete();
    record_seq(2, 4'h4);
    check_eq("abort_err_cleared", err, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_state", dbg_state, S_DONE);
    check_eq("abort_rd_en", rd_en, 0);
    check_eq("abort_done", done, 1);
    check_eq("abort_err", err, 0);
    tick();
    check_eq("abort_idle", dbg_state, S_IDLE);
    check_eq("abort_rd_after", rd_en, 0);
    exp_q.delete();
    flush_fifo();

    // Underflow on the first replay read
    record_seq(3, 4'h1);
    force_empty = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("unf_rd_en", rd_en, 1);
    tick();
    check_eq("unf_rd_low", rd_en, 0);
    check_eq("unf_err", err, 2'b10);
    check_eq("unf_state", dbg_state, S_DONE);
    tick();
    check_eq("unf_no_valid", rep_valid, 0);
    check_eq("unf_idle", dbg_state, S_IDLE);
    force_empty = 1'b0;
    exp_q.delete();
    flush_fifo();

    // Zero length and held start never arm
    rec_len = 16'd0;
    start   = 1'b1;
    tick();
    check_eq("len0_idle", busy, 0);
    rec_len = 16'd3;
    tick();
    tick();
    check_eq("held_start_idle", busy, 0);
    start = 1'b0;
    tick();

    // Oversized length clamps to M_MAX writes
    rec_len = 16'd40000;
    start   = 1'b1;
    tick();
    start    = 1'b0;
    wr_count = 0;
    for (int i = 0; i < 30000; i++) begin
      tick();
      if (wr_en) wr_count++;
      if (dbg_state == S_WAIT) break;
    end
    check_eq("clamp_reached_wait", dbg_state, S_WAIT);
    check_eq("clamp_writes", wr_count, 28000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("clamp_abort_done", done, 1);
    tick();
    flush_fifo();

    // Reset mid-replay, then a clean run
    mode = MODE_PASS;
    record_seq(4, 4'h3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_eq("mid_rep_valid", rep_valid, 1);
    rst = 1'b0;
    #1;
    check_eq("arst_rd_en", rd_en, 0);
    check_eq("arst_rep_valid", rep_valid, 0);
    check_eq("arst_shifted", shifted_dout, 0);
    check_eq("arst_dout", dout, 0);
    check_eq("arst_to_fifo", to_fifo, 0);
    check_eq("arst_comb", dout_comb, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_state", dbg_state, S_IDLE);
    tick();
    rst = 1'b1;
    exp_q.delete();
    flush_fifo();
    record_seq(3, 4'h7);
    replay_seq(3);
    check_eq("t6_seen", n_seen, 3);
    for (int i = 0; i < 3; i++) check_eq("t6_pass_comb", comb_seen[i], pass_exp[i]);
    check_eq("t6_err", err, 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
